// File: rtl/scalar_writeback_unit_if.sv
// scalar_writeback_unit_if: result sources, register-file write port and hazard query bundle.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
interface scalar_writeback_unit_if #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic                  enable;
  logic                  issue_valid;
  logic [4:0]            issue_rd;
  logic                  lsu_valid, lsu_ready;
  logic [4:0]            lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  v2s_valid, v2s_ready;
  logic [4:0]            v2s_rd;
  logic [DATA_WIDTH-1:0] v2s_data;
  logic                  alu_valid, alu_ready;
  logic [4:0]            alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  wb_valid, wb_ready;
  logic [4:0]            wb_rd_address;
  logic [DATA_WIDTH-1:0] wb_data;
  logic [4:0]            query_rs1, query_rs2;
  logic                  rs1_pending, rs2_pending;
  logic                  mask_write;
  logic [CW-1:0]         fifo_count;
  logic                  idle;
  logic                  issue_error;
  modport slave (
    input  enable, issue_valid, issue_rd,
           lsu_valid, lsu_rd, lsu_data, v2s_valid, v2s_rd, v2s_data,
           alu_valid, alu_rd, alu_data, wb_ready, query_rs1, query_rs2,
    output lsu_ready, v2s_ready, alu_ready, wb_valid, wb_rd_address, wb_data,
           rs1_pending, rs2_pending, mask_write, fifo_count, idle, issue_error
  );
  modport master (
    output enable, issue_valid, issue_rd,
           lsu_valid, lsu_rd, lsu_data, v2s_valid, v2s_rd, v2s_data,
           alu_valid, alu_rd, alu_data, wb_ready, query_rs1, query_rs2,
    input  lsu_ready, v2s_ready, alu_ready, wb_valid, wb_rd_address, wb_data,
           rs1_pending, rs2_pending, mask_write, fifo_count, idle, issue_error
  );
endinterface

// File: rtl/scalar_writeback_unit.sv
// scalar_writeback_unit: arbitrates LSU/V2S/ALU results into an ordered writeback queue
// and tracks pending scalar destinations for operand hazard checks.
module scalar_writeback_unit #(
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int FIFO_DEPTH = 4
) (
  input logic                    clk_i,
  input logic                    reset_ni,
  scalar_writeback_unit_if.slave swb_io
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH+4:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           pend_q, pend_d;
  logic                  err_q, err_d, mask_q, mask_d;
  logic                  act, pop, space, push, iss;
  logic [4:0]            sel_rd, head_rd;
  logic [DATA_WIDTH-1:0] sel_data;
  // Everything is gated while reset is held so nothing moves until it is released.
  always_comb begin
    act = swb_io.enable & reset_ni;
    head_rd = mem_q[rd_q][DATA_WIDTH+:5];
    pop = act & (cnt_q != '0) & swb_io.wb_ready;
    space = (cnt_q < CW'(FIFO_DEPTH)) | pop;
    swb_io.lsu_ready = act & space & swb_io.lsu_valid;
    swb_io.v2s_ready = act & space & swb_io.v2s_valid & ~swb_io.lsu_valid;
    swb_io.alu_ready = act & space & swb_io.alu_valid & ~swb_io.lsu_valid & ~swb_io.v2s_valid;
    sel_rd = swb_io.lsu_valid ? swb_io.lsu_rd : swb_io.v2s_valid ? swb_io.v2s_rd : swb_io.alu_rd;
    sel_data = swb_io.lsu_valid ? swb_io.lsu_data : swb_io.v2s_valid ? swb_io.v2s_data : swb_io.alu_data;
    push = (swb_io.lsu_ready | swb_io.v2s_ready | swb_io.alu_ready) & (sel_rd != 5'd0);
    iss = act & swb_io.issue_valid & (swb_io.issue_rd != 5'd0);
    wr_d = wr_q + AW'(push);
    rd_d = rd_q + AW'(pop);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    pend_d = (pend_q & ~(pop ? 32'd1 << head_rd : 32'd0)) | (iss ? 32'd1 << swb_io.issue_rd : 32'd0);
    err_d = err_q | (iss & pend_q[swb_io.issue_rd] & ~(pop & (head_rd == swb_io.issue_rd)));
    mask_d = pop & (head_rd == 5'd31);
    swb_io.wb_valid = act & (cnt_q != '0);
    swb_io.wb_rd_address = head_rd;
    swb_io.wb_data = mem_q[rd_q][DATA_WIDTH-1:0];
    swb_io.rs1_pending = pend_q[swb_io.query_rs1];
    swb_io.rs2_pending = pend_q[swb_io.query_rs2];
    swb_io.mask_write = mask_q;
    swb_io.fifo_count = cnt_q;
    swb_io.idle = (cnt_q == '0) & (pend_q == '0);
    swb_io.issue_error = err_q;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      pend_q <= '0;
      err_q <= 1'b0;
      mask_q <= 1'b0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      pend_q <= pend_d;
      err_q <= err_d;
      mask_q <= mask_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= {sel_rd, sel_data};
  end
endmodule

// File: doc/scalar_writeback_unit.md
SCALAR_WRITEBACK_UNIT -- requirements
Module: scalar_writeback_unit

Interface
REQ-001 Parameters: DATA_WIDTH, default `DATA_WIDTH (32), result width; FIFO_DEPTH, default 4, power of two, writeback queue entries.
REQ-002 clk  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-low reset; 0 at a posedge resets all state.
REQ-004 enable  in  1  warp enable; 0 freezes all state.
REQ-005 issue_valid / issue_rd  in  1 / 5  instruction issued that will write scalar rd.
REQ-006 lsu_valid / lsu_ready / lsu_rd / lsu_data  in / out / in / in  1 / 1 / 5 / DATA_WIDTH  LSU result.
REQ-007 v2s_valid / v2s_ready / v2s_rd / v2s_data  in / out / in / in  1 / 1 / 5 / DATA_WIDTH  vector-to-scalar result.
REQ-008 alu_valid / alu_ready / alu_rd / alu_data  in / out / in / in  1 / 1 / 5 / DATA_WIDTH  ALU result.
REQ-009 wb_valid / wb_ready / wb_rd_address / wb_data  out / in / out / out  1 / 1 / 5 / DATA_WIDTH  register-file write port.
REQ-010 query_rs1 / query_rs2  in  5 each  operand addresses under hazard check.
REQ-011 rs1_pending / rs2_pending  out  1 each  operand has an outstanding write.
REQ-012 mask_write  out  1  one-cycle pulse: register 31 (execution mask) was written.
REQ-013 fifo_count  out  $clog2(FIFO_DEPTH)+1  entries queued.
REQ-014 idle  out  1  queue empty and no register pending.
REQ-015 issue_error  out  1  sticky: issue to an already-pending register.

Function
REQ-016 Fixed-priority arbitration, one accept per cycle: LSU > V2S > ALU.
REQ-017 x_ready is combinational: 1 only for the highest-priority valid source, and only when enable=1 and (fifo_count < FIFO_DEPTH or a pop occurs this cycle); all readies 0 otherwise.
REQ-018 Transfer on x_valid & x_ready; entry {rd, data} pushed at that posedge.
REQ-019 Accepted results with rd = 0 are consumed (ready as per REQ-017) but not enqueued.
REQ-020 wb_valid = enable & (fifo_count != 0); wb_rd_address/wb_data show queue head combinationally from storage.
REQ-021 Pop on wb_valid & wb_ready; latency: accepted at edge N -> wb_valid high in cycle after N when queue was empty.
REQ-022 Order preserved: wb writes leave in acceptance order.
REQ-023 Simultaneous push and pop when full is legal; count unchanged, no loss.
REQ-024 Read/write pointers wrap modulo FIFO_DEPTH.
REQ-025 Scoreboard pending[31:0]: issue_valid & enable & issue_rd != 0 sets pending[issue_rd]; pop clears pending[wb_rd_address].
REQ-026 Same-cycle set and clear of the same register: set wins.
REQ-027 Issue to a register already pending (not cleared that cycle) sets issue_error; bit stays set.
REQ-028 rsN_pending = pending[query_rsN] combinationally; register 0 never pending.
REQ-029 mask_write registered: high one cycle after a pop with wb_rd_address = 31.
REQ-030 idle = (fifo_count == 0) & (pending == 0).
REQ-031 enable = 0: no push, no pop, no scoreboard update; mask_write deasserts next cycle.

Reset
REQ-032 On reset = 0 at posedge: pointers and fifo_count 0, pending all 0, issue_error 0, mask_write 0; hence wb_valid 0, all readies 0 until reset = 1, idle 1.
REQ-033 Reset mid-operation discards queued entries and pending bits; no wb write in the following cycle.

Verification
REQ-034 Issue rd=5, ALU delivers rd=5 data 0xAB next cycle, wb_ready=1 -> rs1_pending(query 5) high 2 cycles, wb write {5,0xAB} one cycle after accept, then idle=1.
REQ-035 LSU, V2S, ALU all valid same cycle, wb_ready=1 -> accept order LSU, V2S, ALU over 3 cycles; writes in same order.
REQ-036 wb_ready=0, ALU pushes 5 results (depth 4) -> 4 accepted, alu_ready 0 on 5th until one pop; count never exceeds 4; drain preserves order.
REQ-037 Write rd=31 data 0x0000_000F -> mask_write single pulse cycle after pop; rd=0 result consumed, no wb_valid.
REQ-038 Issue rd=7 twice without writeback -> issue_error=1 and sticky; reset=0 one cycle -> error 0, fifo_count 0, pending 0.
